// File: rtl/fpu_pkg.sv
// Shared encodings for the fpu issue controller: request op codes, FSM states,
// the canonical quiet NaN and the default fpu pipeline latency.
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_SUB = 2'b10,
    OP_ILL = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [31:0] QNAN        = 32'h7FC0_0000;
  localparam int          FPU_LAT_DEF = 2;

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational request decode: legality, fpu op bit and the operand B actually issued.
// Subtraction is only legal when FPU_SUB_EN is defined; it becomes an add with B negated.
module fpu_op_decode
  import fpu_pkg::*;
(
  input  logic [1:0]  req_op,
  input  logic [31:0] req_b,
  output logic        legal,
  output logic        fpu_op,
  output logic [31:0] fpu_b
);

  always_comb begin
    legal  = 1'b0;
    fpu_op = 1'b0;
    fpu_b  = req_b;
    case (req_op)
      OP_ADD: legal = 1'b1;
      OP_MUL: begin
        legal  = 1'b1;
        fpu_op = 1'b1;
      end
`ifdef FPU_SUB_EN
      // a - b is issued as a + (-b); flipping the sign bit is exact for every encoding
      OP_SUB: begin
        legal = 1'b1;
        fpu_b = {~req_b[31], req_b[30:0]};
      end
`endif
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Front-end sequencer for the fpu core: one op in flight, fixed-latency result capture,
// tagged response. Optional macro FPU_SUB_EN enables op 10 (subtract).
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int FPU_LAT = FPU_LAT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [1:0]       i_req_op,
  input  logic [31:0]      i_req_a,
  input  logic [31:0]      i_req_b,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic [31:0]      o_fpu_data_1,
  output logic [31:0]      o_fpu_data_2,
  output logic             o_fpu_op,
  output logic             o_fpu_valid,
  input  logic [31:0]      i_fpu_data_out,
  input  logic             i_fpu_out_valid,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [31:0]      o_rsp_data,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic             o_rsp_err,
  output logic [CNT_W-1:0] o_op_count
);

  localparam int WCNT_W = (FPU_LAT > 2) ? $clog2(FPU_LAT) : 1;

  state_t            state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              dec_legal;
  logic              dec_fpu_op;
  logic [31:0]       dec_b;

  fpu_op_decode u_decode (
    .req_op (i_req_op),
    .req_b  (i_req_b),
    .legal  (dec_legal),
    .fpu_op (dec_fpu_op),
    .fpu_b  (dec_b)
  );

  // Operands are loaded at accept so they are already stable through ISSUE and WAIT;
  // an illegal op leaves the fpu-side outputs untouched and goes straight to RESP.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      o_req_ready  <= 1'b1;
      o_fpu_data_1 <= '0;
      o_fpu_data_2 <= '0;
      o_fpu_op     <= 1'b0;
      o_fpu_valid  <= 1'b0;
      o_rsp_valid  <= 1'b0;
      o_rsp_data   <= '0;
      o_rsp_tag    <= '0;
      o_rsp_err    <= 1'b0;
      o_op_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req_valid && o_req_ready) begin
            o_req_ready <= 1'b0;
            o_rsp_tag   <= i_req_tag;
            if (dec_legal) begin
              o_fpu_data_1 <= i_req_a;
              o_fpu_data_2 <= dec_b;
              o_fpu_op     <= dec_fpu_op;
              o_fpu_valid  <= 1'b1;
              state        <= ST_ISSUE;
            end else begin
              o_rsp_data  <= QNAN;
              o_rsp_err   <= 1'b1;
              o_rsp_valid <= 1'b1;
              state       <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          o_fpu_valid <= 1'b0;
          wait_cnt    <= WCNT_W'(FPU_LAT - 1);
          state       <= ST_WAIT;
        end
        // The edge that sees wait_cnt==0 is the FPU_LAT-th edge after the issue edge
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            o_rsp_data  <= i_fpu_data_out;
            o_rsp_err   <= ~i_fpu_out_valid;
            o_rsp_valid <= 1'b1;
            state       <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_op_count  <= o_op_count + 1'b1;
            o_req_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
